result_collector: RTL and testbench
===================================

# result_collector

Downstream stage of the data interface: captures the result words it emits (`y_valid`), frames them against the announced output length (`out_count` / `out_count_valid`) and buffers them in a FIFO. The host drains the FIFO through a valid/ready stream. Each frame is one header word carrying the expected length, followed by that many result words; the final word of the frame carries a last marker.

## Interface
Parameters:
- `WIDTH`, 32: data word width; must match the data interface bus.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  global clock; all logic on its rising edge.
- `clear`  in  1  global reset, synchronous, active-high.
- `enable`  in  1  global enable; gates capture only; the host side always runs.
- `y_data`  in  WIDTH  result word from the data interface.
- `y_valid`  in  1  `y_data` valid this cycle.
- `out_count`  in  32  expected result count for the next frame.
- `out_count_valid`  in  1  `out_count` valid this cycle.
- `m_data`  out  WIDTH  stream word to host.
- `m_last`  out  1  `m_data` is the final word of its frame.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  host accepts the word.
- `busy`  out  1  frame in collection or FIFO non-empty.
- `overflow`  out  1  sticky; a push was dropped because the FIFO was full.
- `frame_done`  out  1  one-cycle pulse after the host accepts a last word.

## Operation
- **Reset state.** While `clear` is high: state = IDLE, FIFO empty, `remaining` = 0. All outputs are 0: `m_valid`, `m_last`, `busy`, `overflow`, `frame_done`. `m_data` is 0.
- **IDLE.**
  - On `enable & out_count_valid`: push header word `{last = (out_count == 0), data = out_count}` and load `remaining` = `out_count`.
  - Next state is COLLECT if `out_count != 0`, otherwise IDLE.
  - `y_valid` is ignored in IDLE, including in the same cycle as `out_count_valid`.
- **COLLECT.**
  - On `enable & y_valid`: push `{last = (remaining == 1), data = y_data}` and decrement `remaining`.
  - On `remaining == 1` with a push, return to IDLE.
  - `out_count_valid` is ignored in COLLECT.
  - `enable` low freezes capture and `remaining`.
- **Push and pop.**
  - At most one push and one pop per cycle.
  - Pop occurs when `m_valid & m_ready`.
  - Push when full without a simultaneous pop: the word is dropped and `overflow` is set. `remaining` and the state still advance, so framing stays aligned with the upstream block.
  - Full FIFO with a simultaneous pop: the push succeeds.
  - Empty FIFO with a simultaneous push: no pop. The word appears next cycle.
- **Stream rules.**
  - `m_data` and `m_last` are held stable while `m_valid & !m_ready`.
  - `m_valid` never drops without a handshake, except on `clear`.
- **Status outputs.**
  - `frame_done` is registered: high exactly one cycle after a handshake with `m_last` = 1.
  - `busy` = (state == COLLECT) | (occupancy != 0).
- **Arithmetic and widths.**
  - `remaining` is 32-bit unsigned.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- **Reset mid-operation.** `clear` in any state discards FIFO contents and any partial frame in the same edge. `overflow` clears only on `clear`.

## Timing
- Capture to `m_valid`: 1 cycle. A word pushed at edge t is visible after edge t, with no combinational path from the `y_*` inputs to the `m_*` outputs.
- `m_data`, `m_last` and `m_valid` derive from registers only. `m_ready` affects state only at the next edge.
- Sustained throughput is one word per cycle in each direction.
- Header-to-first-result gap is at least 1 cycle, because `y_valid` in the header cycle is ignored.

## Structure
- Shared package holds:
  - state enum {IDLE, COLLECT};
  - the FIFO entry layout (`WIDTH`+1 bits, last flag in MSB);
  - the `out_count` width constant, 32.
- Sub-module `result_fifo`: synchronous FIFO parameterised by width and depth, with push/pop/full/empty/occupancy. The top level holds the framing FSM, `remaining`, the overflow flag and `frame_done`.

## Test plan
- **Basic frame.** `out_count`=3, then `y_data` 0xA, 0xB, 0xC with `m_ready`=1 → stream 3, 0xA, 0xB, 0xC; `m_last` only on 0xC; `frame_done` pulses once; `busy` returns to 0.
- **Zero-length frame.** `out_count`=0 → single word 0 with `m_last`=1. State remains IDLE; a following `y_valid` pushes nothing.
- **Backpressure.** `m_ready`=0 with `DEPTH`=4, `out_count`=3, 3 results → occupancy 4, no overflow, `m_data`=3 held stable. Then release `m_ready` → 4 words in order.
- **Overflow.** `DEPTH`=4, `m_ready`=0, `out_count`=5, 5 results → `overflow`=1 after the 4th result. The state still returns to IDLE. The FIFO holds 5, r1, r2, r3.
- **Gating and reset.** `enable`=0 during `y_valid` pulses → nothing pushed and `remaining` unchanged. `clear` mid-frame → `m_valid`=0, `busy`=0, `overflow`=0 on the next cycle.

Source files
------------

// File: rtl/result_collector_pkg.sv
// result_collector_pkg: shared state type, count width and FIFO entry layout
package result_collector_pkg;
  typedef enum logic {IDLE, COLLECT} state_t;
  localparam int COUNT_W = 32;
  function automatic int entry_w(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with simultaneous push/pop and occupancy count
module result_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
    rdata = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/result_collector.sv
// result_collector: frames result words behind a length header and streams them to the host
module result_collector
  import result_collector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic [WIDTH-1:0]   y_data,
  input  logic               y_valid,
  input  logic [COUNT_W-1:0] out_count,
  input  logic               out_count_valid,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               overflow,
  output logic               frame_done
);
  localparam int EW = entry_w(WIDTH);
  state_t state;
  logic [COUNT_W-1:0] remaining;
  logic hdr, dat, push, pop, full, empty;
  logic [EW-1:0] wdata, rdata;
  logic [$clog2(DEPTH):0] count;
  result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .clear(clear),
    .push(push),
    .pop(pop),
    .wdata(wdata),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    hdr = state == IDLE && enable && out_count_valid;
    dat = state == COLLECT && enable && y_valid;
    push = hdr | dat;
    wdata = hdr ? {out_count == '0, WIDTH'(out_count)} : {remaining == COUNT_W'(1), y_data};
    m_valid = !empty;
    m_data = m_valid ? rdata[WIDTH-1:0] : '0;
    m_last = m_valid & rdata[WIDTH];
    pop = m_valid & m_ready;
    busy = state == COLLECT || count != '0;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      remaining <= '0;
      overflow <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= hdr ? (out_count != '0 ? COLLECT : IDLE) : (dat && remaining == COUNT_W'(1)) ? IDLE : state;
      remaining <= hdr ? out_count : dat ? remaining - 1'b1 : remaining;
      overflow <= overflow | (push & full & !pop);
      frame_done <= pop & m_last;
    end
  end
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: table-driven and directed checks of framing, backpressure, overflow, gating and clear
module tb_result_collector;
  logic clk = 1'b0;
  logic clear, enable, y_valid, out_count_valid, m_ready;
  logic [31:0] y_data, out_count, m_data;
  logic m_last, m_valid, busy, overflow, frame_done;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic en;
    logic ocv;
    logic [31:0] oc;
    logic yv;
    logic [31:0] yd;
    logic rdy;
    logic ev;
    logic [31:0] ed;
    logic el;
    logic eb;
    logic efd;
  } vec_t;
  vec_t tbl[9];
  logic [31:0] exp_words[4];
  result_collector #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk),
    .clear(clear),
    .enable(enable),
    .y_data(y_data),
    .y_valid(y_valid),
    .out_count(out_count),
    .out_count_valid(out_count_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy),
    .overflow(overflow),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic step(input logic c, input logic e, input logic ov, input logic [31:0] oc,
                      input logic yv, input logic [31:0] yd, input logic r);
    clear = c;
    enable = e;
    out_count_valid = ov;
    out_count = oc;
    y_valid = yv;
    y_data = yd;
    m_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  initial begin
    tbl[0] = '{1, 1, 3, 1, 'h55, 1, 1, 3, 0, 1, 0};
    tbl[1] = '{1, 0, 0, 1, 'hA, 1, 1, 'hA, 0, 1, 0};
    tbl[2] = '{1, 0, 0, 1, 'hB, 1, 1, 'hB, 0, 1, 0};
    tbl[3] = '{1, 0, 0, 1, 'hC, 1, 1, 'hC, 1, 1, 0};
    tbl[4] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[5] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0};
    tbl[7] = '{1, 0, 0, 1, 'h77, 1, 0, 0, 0, 0, 1};
    tbl[8] = '{1, 0, 0, 1, 'h78, 1, 0, 0, 0, 0, 0};
    step(1, 1, 1, 7, 1, 'h99, 1);
    step(1, 1, 1, 7, 1, 'h99, 1);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fd", frame_done, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, tbl[i].en, tbl[i].ocv, tbl[i].oc, tbl[i].yv, tbl[i].yd, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), m_valid, tbl[i].ev);
      chk($sformatf("v%0d_data", i), m_data, tbl[i].ed);
      chk($sformatf("v%0d_last", i), m_last, tbl[i].el);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("v%0d_fd", i), frame_done, tbl[i].efd);
      chk($sformatf("v%0d_ovf", i), overflow, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 0, 0, 0);
    step(0, 1, 0, 0, 1, 'h11, 0);
    step(0, 1, 0, 0, 1, 'h22, 0);
    step(0, 1, 0, 0, 1, 'h33, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_hold", m_data, 3);
    chk("bp_ovf", overflow, 0);
    chk("bp_busy", busy, 1);
    exp_words = '{32'h3, 32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_w%0d_valid", i), m_valid, 1);
      chk($sformatf("bp_w%0d_data", i), m_data, exp_words[i]);
      chk($sformatf("bp_w%0d_last", i), m_last, i == 3);
      step(0, 1, 0, 0, 0, 0, 1);
    end
    chk("bp_drained", m_valid, 0);
    chk("bp_fd", frame_done, 1);
    chk("bp_busy_end", busy, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 0, 1, 32'h100 + i, 0);
      chk($sformatf("ovf_after_r%0d", i), overflow, i >= 4);
    end
    chk("ovf_hold", m_data, 5);
    exp_words = '{32'h5, 32'h101, 32'h102, 32'h103};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_w%0d_data", i), m_data, exp_words[i]);
      chk($sformatf("ovf_w%0d_last", i), m_last, 0);
      step(0, 1, 0, 0, 0, 0, 1);
    end
    chk("ovf_drained", m_valid, 0);
    chk("ovf_idle", busy, 0);
    chk("ovf_no_fd", frame_done, 0);
    chk("ovf_sticky", overflow, 1);
    step(0, 1, 1, 4, 0, 0, 0);
    step(0, 1, 0, 0, 1, 'hD1, 0);
    chk("mid_busy", busy, 1);
    step(1, 1, 0, 0, 1, 'hD2, 0);
    chk("clr_valid", m_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_data", m_data, 0);
    step(0, 1, 0, 0, 1, 'hD3, 0);
    chk("clr_idle_ignore", m_valid, 0);
    step(0, 0, 1, 9, 0, 0, 0);
    chk("gate_hdr", m_valid, 0);
    step(0, 1, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 'hE1, 0);
    step(0, 0, 0, 0, 1, 'hE1, 0);
    chk("gate_data", m_data, 2);
    step(0, 1, 0, 0, 1, 'hE2, 0);
    step(0, 1, 0, 0, 1, 'hE3, 0);
    chk("gate_busy", busy, 1);
    exp_words = '{32'h2, 32'hE2, 32'hE3, 32'h0};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("gate_w%0d_valid", i), m_valid, 1);
      chk($sformatf("gate_w%0d_data", i), m_data, exp_words[i]);
      chk($sformatf("gate_w%0d_last", i), m_last, i == 2);
      step(0, 1, 0, 0, 0, 0, 1);
    end
    chk("gate_drained", m_valid, 0);
    chk("gate_fd", frame_done, 1);
    chk("gate_ovf", overflow, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
